// File: rtl/bus_io_target_if.sv
// Bus-side bundle for bus_io_target: CPU register port, TX/RX byte streams and interrupt.
// The core/testbench side uses master and the target uses slave.
interface bus_io_target_if;
   logic [15:0] address;
   logic        read_en;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;
   logic        hit;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        irq;

   modport master (
      output address, read_en, bus_wdata, tx_ready, rx_data, rx_valid,
      input  bus_rdata, hit, tx_data, tx_valid, rx_ready, irq
   );

   modport slave (
      input  address, read_en, bus_wdata, tx_ready, rx_data, rx_valid,
      output bus_rdata, hit, tx_data, tx_valid, rx_ready, irq
   );
endinterface

// File: rtl/bus_io_target.sv
// Memory-mapped I/O target: 8-deep TX FIFO, 1-byte RX holding register and a
// 16-bit reload timer with interrupt. Every cycle whose address hits the window is a bus access.
module bus_io_target #(
   parameter logic [15:0] BASE = 16'hD000
) (
   input logic             ph2,
   input logic             reset,
   bus_io_target_if.slave  bus
);
   logic [7:0]  r_fifo [8];
   logic [2:0]  r_wptr, r_rptr;
   logic [3:0]  r_count;
   logic        r_ovf;
   logic        r_rx_full;
   logic [7:0]  r_rx_data;
   logic [15:0] r_reload;
   logic [15:0] r_cnt;
   logic        r_tmr_en, r_irq_en;
   logic        r_tmr_flag;
   logic        r_irq;

   logic       w_hit, w_wr, w_rd;
   logic [3:0] w_reg;
   logic       w_tx_full, w_tx_empty, w_push, w_pop, w_push_ok;
   logic       w_tmr_expire, w_tmr_start;
   logic [7:0] w_rdata;

   assign w_hit        = (bus.address[15:4] == BASE[15:4]);
   assign w_reg        = bus.address[3:0];
   assign w_wr         = w_hit && !bus.read_en;
   assign w_rd         = w_hit && bus.read_en;
   assign w_tx_full    = (r_count == 4'd8);
   assign w_tx_empty   = (r_count == 4'd0);
   assign w_push       = w_wr && (w_reg == 4'h0);
   assign w_pop        = !w_tx_empty && bus.tx_ready;
   // A full FIFO still takes the push when the head leaves on the same edge.
   assign w_push_ok    = w_push && (!w_tx_full || w_pop);
   assign w_tmr_expire = r_tmr_en && (r_cnt == 16'h0000);
   assign w_tmr_start  = w_wr && (w_reg == 4'h4) && bus.bus_wdata[0] && !r_tmr_en;

   always_comb begin
      w_rdata = 8'h00;
      if (w_hit) begin
         case (w_reg)
            4'h0:    w_rdata = r_rx_full ? r_rx_data : 8'h00;
            4'h1:    w_rdata = {r_tmr_flag, r_ovf, 2'b00, r_rx_full, w_tx_full, w_tx_empty, 1'b0};
            4'h2:    w_rdata = r_reload[7:0];
            4'h3:    w_rdata = r_reload[15:8];
            4'h4:    w_rdata = {6'b0, r_irq_en, r_tmr_en};
            default: w_rdata = 8'h00;
         endcase
      end
   end

   assign bus.bus_rdata = w_rdata;
   assign bus.hit       = w_hit;
   assign bus.tx_valid  = !w_tx_empty;
   assign bus.tx_data   = w_tx_empty ? 8'h00 : r_fifo[r_rptr];
   assign bus.rx_ready  = !r_rx_full;
   assign bus.irq       = r_irq;

   always_ff @(posedge ph2 or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) r_fifo[i] <= 8'h00;
         r_wptr  <= 3'd0;
         r_rptr  <= 3'd0;
         r_count <= 4'd0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_fifo[r_wptr] <= bus.bus_wdata;
            r_wptr         <= r_wptr + 3'd1;
         end
         if (w_pop) r_rptr <= r_rptr + 3'd1;
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 4'd1;
            2'b01:   r_count <= r_count - 4'd1;
            default: r_count <= r_count;
         endcase
         if (w_push && !w_push_ok)           r_ovf <= 1'b1;
         else if (w_rd && (w_reg == 4'h1))   r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge ph2 or negedge reset) begin
      if (!reset) begin
         r_rx_full <= 1'b0;
         r_rx_data <= 8'h00;
      end else if (bus.rx_valid && !r_rx_full) begin
         r_rx_full <= 1'b1;
         r_rx_data <= bus.rx_data;
      end else if (w_rd && (w_reg == 4'h0)) begin
         r_rx_full <= 1'b0;
      end
   end

   always_ff @(posedge ph2 or negedge reset) begin
      if (!reset) begin
         r_reload   <= 16'h0000;
         r_cnt      <= 16'h0000;
         r_tmr_en   <= 1'b0;
         r_irq_en   <= 1'b0;
         r_tmr_flag <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         if (w_wr && (w_reg == 4'h2)) r_reload[7:0]  <= bus.bus_wdata;
         if (w_wr && (w_reg == 4'h3)) r_reload[15:8] <= bus.bus_wdata;
         if (w_wr && (w_reg == 4'h4)) begin
            r_tmr_en <= bus.bus_wdata[0];
            r_irq_en <= bus.bus_wdata[1];
         end
         if (w_tmr_start)       r_cnt <= r_reload;
         else if (w_tmr_expire) r_cnt <= r_reload;
         else if (r_tmr_en)     r_cnt <= r_cnt - 16'd1;
         // Expiry beats a same-cycle IRQ_CLR write.
         if (w_tmr_expire)                    r_tmr_flag <= 1'b1;
         else if (w_wr && (w_reg == 4'h5))    r_tmr_flag <= 1'b0;
         r_irq <= r_tmr_flag && r_irq_en;
      end
   end
endmodule

// File: tb/tb_bus_io_target.sv
// Directed bench for bus_io_target: table of bus cycles plus hand-written
// sequences for FIFO streaming, RX handshake, timer/irq and mid-transfer reset.
module tb_bus_io_target;
   logic ph2 = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass = 0;
   int   n_chk  = 0;

   bus_io_target_if bif();

   bus_io_target #(.BASE(16'hD000)) dut (
      .ph2   (ph2),
      .reset (rst_n),
      .bus   (bif)
   );

   always #5 ph2 = ~ph2;

   typedef struct {
      logic [15:0] addr;
      logic        rd;
      logic [7:0]  wd;
      logic [7:0]  exp;
      logic        exp_hit;
      string       nm;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic add(input logic [15:0] a, input logic rd, input logic [7:0] wd,
                      input logic [7:0] exp, input logic h, input string nm);
      vec_t v;
      v.addr = a; v.rd = rd; v.wd = wd; v.exp = exp; v.exp_hit = h; v.nm = nm;
      vq.push_back(v);
   endtask

   task automatic tick();
      @(posedge ph2);
      #1;
   endtask

   task automatic park();
      bif.address   = 16'h0000;
      bif.read_en   = 1'b1;
      bif.bus_wdata = 8'h00;
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
      bif.address = a; bif.read_en = 1'b0; bif.bus_wdata = d;
      tick();
      park();
   endtask

   task automatic bus_rd(input logic [15:0] a, input logic [7:0] exp, input string nm);
      bif.address = a; bif.read_en = 1'b1;
      #1;
      chk(nm, {8'h00, bif.bus_rdata}, {8'h00, exp});
      tick();
      park();
   endtask

   task automatic drain(input logic [7:0] first, input int n, input string nm);
      bif.tx_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         chk({nm, "_vld"}, {15'h0, bif.tx_valid}, 16'h0001);
         chk({nm, "_dat"}, {8'h00, bif.tx_data}, {8'h00, first + 8'(i)});
         tick();
      end
      chk({nm, "_empty"}, {15'h0, bif.tx_valid}, 16'h0000);
      bif.tx_ready = 1'b0;
   endtask

   initial begin
      park();
      bif.tx_ready = 1'b0;
      bif.rx_data  = 8'h00;
      bif.rx_valid = 1'b0;

      // Reset state
      #2;
      chk("rst_tx_valid", {15'h0, bif.tx_valid}, 16'h0000);
      chk("rst_tx_data",  {8'h00, bif.tx_data},  16'h0000);
      chk("rst_rx_ready", {15'h0, bif.rx_ready}, 16'h0001);
      chk("rst_irq",      {15'h0, bif.irq},      16'h0000);
      tick();
      rst_n = 1'b1;
      tick();

      // Register map, overflow and window boundaries (tx_ready held low)
      add(16'hD001, 1, 8'h00, 8'h02, 1, "st_reset");
      add(16'hD000, 1, 8'h00, 8'h00, 1, "rx_empty");
      add(16'hD004, 1, 8'h00, 8'h00, 1, "ctrl_reset");
      add(16'hD002, 1, 8'h00, 8'h00, 1, "rlo_reset");
      add(16'hD002, 0, 8'h34, 8'h00, 1, "wr_rlo");
      add(16'hD003, 0, 8'h12, 8'h00, 1, "wr_rhi");
      add(16'hD002, 1, 8'h00, 8'h34, 1, "rd_rlo");
      add(16'hD003, 1, 8'h00, 8'h12, 1, "rd_rhi");
      add(16'hD004, 0, 8'hFE, 8'h00, 1, "wr_ctrl");
      add(16'hD004, 1, 8'h00, 8'h02, 1, "rd_ctrl");
      add(16'hD004, 0, 8'h00, 8'h00, 1, "clr_ctrl");
      for (int i = 0; i < 9; i++) add(16'hD000, 0, 8'h10 + 8'(i), 8'h00, 1, "push");
      add(16'hD001, 1, 8'h00, 8'h44, 1, "st_ovf_full");
      add(16'hD001, 1, 8'h00, 8'h04, 1, "st_ovf_clr");
      add(16'hD00F, 1, 8'h00, 8'h00, 1, "rd_resv");
      add(16'hD010, 0, 8'h99, 8'h00, 0, "wr_offwin");
      add(16'hD010, 1, 8'h00, 8'h00, 0, "rd_offwin");
      add(16'hCFFF, 1, 8'h00, 8'h00, 0, "rd_below");
      add(16'hD00A, 0, 8'h55, 8'h00, 1, "wr_resv");
      add(16'hD001, 1, 8'h00, 8'h04, 1, "st_unchanged");

      foreach (vq[k]) begin
         bif.address = vq[k].addr; bif.read_en = vq[k].rd; bif.bus_wdata = vq[k].wd;
         #1;
         chk({vq[k].nm, "_hit"}, {15'h0, bif.hit}, {15'h0, vq[k].exp_hit});
         if (vq[k].rd) chk(vq[k].nm, {8'h00, bif.bus_rdata}, {8'h00, vq[k].exp});
         tick();
         park();
      end
      drain(8'h10, 8, "ovf_drain");

      // Three bytes queued then streamed on consecutive cycles
      bus_wr(16'hD000, 8'hA1);
      bus_wr(16'hD000, 8'hB2);
      bus_wr(16'hD000, 8'hC3);
      chk("seq_a1", {8'h00, bif.tx_data}, 16'h00A1);
      bif.tx_ready = 1'b1;
      chk("seq_a1_cyc", {8'h00, bif.tx_data}, 16'h00A1);
      tick();
      chk("seq_b2", {8'h00, bif.tx_data}, 16'h00B2);
      tick();
      chk("seq_c3", {8'h00, bif.tx_data}, 16'h00C3);
      tick();
      chk("seq_done", {15'h0, bif.tx_valid}, 16'h0000);
      bif.tx_ready = 1'b0;

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 8; i++) bus_wr(16'hD000, 8'h20 + 8'(i));
      bif.address = 16'hD000; bif.read_en = 1'b0; bif.bus_wdata = 8'h28;
      bif.tx_ready = 1'b1;
      tick();
      park();
      bif.tx_ready = 1'b0;
      bus_rd(16'hD001, 8'h04, "full_pushpop_st");
      drain(8'h21, 8, "full_pushpop");

      // RX handshake
      bif.rx_data = 8'h5A; bif.rx_valid = 1'b1;
      chk("rx_rdy_pre", {15'h0, bif.rx_ready}, 16'h0001);
      tick();
      bif.rx_data = 8'h77;
      chk("rx_rdy_full", {15'h0, bif.rx_ready}, 16'h0000);
      tick();
      bif.rx_valid = 1'b0;
      bus_rd(16'hD001, 8'h0A, "rx_st_full");
      bus_rd(16'hD000, 8'h5A, "rx_data");
      chk("rx_rdy_post", {15'h0, bif.rx_ready}, 16'h0001);
      bus_rd(16'hD000, 8'h00, "rx_after");

      // Timer with reload 3 and irq enabled
      bus_wr(16'hD002, 8'h03);
      bus_wr(16'hD003, 8'h00);
      bus_wr(16'hD004, 8'h03);              // load edge E0
      tick(); tick(); tick();               // E3
      bif.address = 16'hD001;
      #1;
      chk("tmr_noflag", {8'h00, bif.bus_rdata}, 16'h0002);
      tick();                               // E4
      chk("tmr_flag", {8'h00, bif.bus_rdata}, 16'h0082);
      chk("irq_lag", {15'h0, bif.irq}, 16'h0000);
      park();
      tick();                               // E5
      chk("irq_rise", {15'h0, bif.irq}, 16'h0001);
      bus_wr(16'hD005, 8'h00);              // clear at E6
      tick();                               // E7
      chk("irq_clr", {15'h0, bif.irq}, 16'h0000);

      // Reload 0 expires every cycle, so the set beats IRQ_CLR
      bus_wr(16'hD004, 8'h00);
      bus_wr(16'hD005, 8'h00);
      bus_wr(16'hD002, 8'h00);
      bus_rd(16'hD001, 8'h02, "tmr_off_st");
      bus_wr(16'hD004, 8'h01);
      tick();
      bus_wr(16'hD005, 8'h00);
      bus_rd(16'hD001, 8'h82, "set_wins");
      bus_wr(16'hD004, 8'h00);
      bus_wr(16'hD005, 8'h00);
      bus_rd(16'hD001, 8'h02, "clr_after_stop");
      chk("irq_off", {15'h0, bif.irq}, 16'h0000);

      // Reset mid-transfer
      bus_wr(16'hD000, 8'hE1);
      bus_wr(16'hD000, 8'hE2);
      bus_wr(16'hD004, 8'h02);
      bif.rx_data = 8'h3C; bif.rx_valid = 1'b1;
      tick();
      bif.rx_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      bif.address = 16'hD001;
      #1;
      chk("mid_rst_st", {8'h00, bif.bus_rdata}, 16'h0002);
      chk("mid_rst_txv", {15'h0, bif.tx_valid}, 16'h0000);
      chk("mid_rst_rxr", {15'h0, bif.rx_ready}, 16'h0001);
      park();
      tick();
      rst_n = 1'b1;
      tick();
      bus_rd(16'hD000, 8'h00, "post_rst_rx");
      bus_rd(16'hD004, 8'h00, "post_rst_ctrl");
      chk("post_rst_txd", {8'h00, bif.tx_data}, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/bus_io_target.md
BUS_IO_TARGET -- requirements
Module: bus_io_target

Interface
REQ-001 SHALL have port ph2, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset; 0 clears all state immediately.
REQ-003 SHALL have port address, input, 16, bus address driven by the CPU core.
REQ-004 SHALL have port read_en, input, 1, 1 = CPU read cycle, 0 = CPU write cycle.
REQ-005 SHALL have port bus_wdata, input, 8, CPU write data (the core's data_out).
REQ-006 SHALL have port bus_rdata, output, 8, read data returned to the core's data_in.
REQ-007 SHALL have port hit, output, 1, high when address is inside this block's window.
REQ-008 SHALL have ports tx_data (output, 8), tx_valid (output, 1) and tx_ready (input, 1), the outbound byte stream.
REQ-009 SHALL have ports rx_data (input, 8), rx_valid (input, 1) and rx_ready (output, 1), the inbound byte stream.
REQ-010 SHALL have port irq, output, 1, active-high interrupt request.
REQ-011 SHALL have parameter BASE, default 16'hD000, the window base; the window is BASE[15:4] with 16 byte registers.

Function
REQ-012 hit SHALL equal (address[15:4] == BASE[15:4]) combinationally; off-window cycles SHALL have no side effects and bus_rdata SHALL be 8'h00.
REQ-013 Register map by address[3:0]: 0 DATA, 1 STATUS, 2 RELOAD_LO, 3 RELOAD_HI, 4 CTRL, 5 IRQ_CLR; 6..F reads SHALL return 8'h00 and writes SHALL be ignored.
REQ-014 bus_rdata SHALL be combinational from the current register state (zero-wait-state, same-cycle read); side effects of a read SHALL occur at the clock edge ending that cycle.
REQ-015 TX FIFO: 8 entries × 8 bits; a write to DATA SHALL push bus_wdata; a push while full SHALL be dropped and SHALL set STATUS.ovf.
REQ-016 tx_valid SHALL equal FIFO not-empty; tx_data SHALL be the head entry; a pop SHALL occur on an edge where tx_valid && tx_ready.
REQ-017 A push and a pop in the same cycle SHALL both take effect; the count is unchanged, and a full FIFO SHALL accept the push.
REQ-018 The FIFO pointers SHALL be 3 bits wrapping 7->0; the count SHALL be 4 bits, range 0..8.
REQ-019 RX holding register: 1 byte with full flag; rx_ready SHALL equal !rx_full; on an edge with rx_valid && rx_ready, capture rx_data and set rx_full.
REQ-020 A read of DATA SHALL return the RX byte, with the RX byte reading 8'h00 when empty, and SHALL clear rx_full at that edge; a capture in the same cycle SHALL be impossible because rx_ready is low while full.
REQ-021 STATUS bits SHALL be {tmr_flag, ovf, 2'b0, rx_full, tx_full, tx_empty, 1'b0} (bit7..bit0); reading STATUS SHALL clear ovf.
REQ-022 Timer: 16-bit down counter; RELOAD_LO/HI writes SHALL update the reload value only.
REQ-023 CTRL bit0 is tmr_en and bit1 is irq_en; other bits SHALL read 0. A CTRL write with bit0 rising 0->1 SHALL load the counter with the reload value.
REQ-024 While tmr_en is set, the counter SHALL decrement each cycle; on a cycle where it is 0, it SHALL reload and set tmr_flag. A reload value of 0 SHALL set tmr_flag every cycle.
REQ-025 A write to IRQ_CLR with any data SHALL clear tmr_flag; if the timer expires in the same cycle, the set SHALL win.
REQ-026 irq SHALL be registered and SHALL equal tmr_flag && irq_en as of the previous edge (one-cycle latency).

Reset
REQ-027 While reset=0: FIFO empty with pointers and count 0, ovf=0, rx_full=0, RELOAD=16'h0000, counter=0, CTRL=0, tmr_flag=0.
REQ-028 Outputs under reset: tx_valid=0, tx_data=8'h00, rx_ready=1, irq=0; bus_rdata stays combinational from the cleared state.
REQ-029 Reset asserted mid-transfer SHALL discard FIFO contents and any pending RX byte; no partial state SHALL survive deassertion.

Verification
REQ-030 Write 8'hA1, 8'hB2, 8'hC3 to D000 with tx_ready=0, then raise tx_ready -> tx_data sequence A1, B2, C3 on consecutive cycles, then tx_valid=0.
REQ-031 Nine writes with tx_ready=0 -> STATUS reads 8'h44 (ovf, tx_full), the ninth byte is lost, and the next STATUS read returns 8'h04.
REQ-032 Full FIFO with a simultaneous write and tx_ready=1 -> count stays 8 and the new byte emerges eighth.
REQ-033 rx_valid with rx_data=8'h5A -> rx_ready drops the next cycle; a read of D000 returns 8'h5A and rx_ready rises after that edge.
REQ-034 RELOAD=16'h0003, CTRL=8'h03 -> tmr_flag sets 4 cycles after load and irq rises one cycle later; an IRQ_CLR write drops irq within 2 cycles.
REQ-035 Read D00F, write to 16'hD010 -> bus_rdata 8'h00, hit=0 for D010, and no state change.
